// File: rtl/ddr_init_monitor.sv
// ddr_init_monitor: checks the SDRAM power-up command stream (PWR, PRE, AREF xN, LMR)
// for order and timing gaps, decodes the mode register and flags the first error.
module ddr_init_monitor #(
    parameter int BA_WIDTH   = 2,
    parameter int ADDR_WIDTH = 13,
    parameter int T_POW      = 350,
    parameter int T_RP       = 4,
    parameter int T_RFC      = 12,
    parameter int T_MRD      = 6,
    parameter int AREF_REQ   = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  mon_en_i,
    input  logic [3:0]            cmd_i,
    input  logic [BA_WIDTH-1:0]   ba_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  dev_ready_o,
    output logic                  mr_valid_o,
    output logic [2:0]            mr_bl_o,
    output logic                  mr_bt_o,
    output logic [2:0]            mr_cl_o,
    output logic                  mr_wbm_o,
    output logic [3:0]            aref_cnt_o,
    output logic                  err_o,
    output logic [2:0]            err_code_o
);
    typedef enum logic [2:0] {M_PWR, M_WPRE, M_TRP, M_TRFC, M_TMRD, M_READY, M_ERR} state_t;

    localparam logic [15:0] POW      = 16'(T_POW);
    localparam logic [7:0]  RP       = 8'(T_RP);
    localparam logic [7:0]  RFC      = 8'(T_RFC);
    localparam logic [7:0]  MRD_LAST = 8'(T_MRD - 1);
    localparam logic [3:0]  AREF_MIN = 4'(AREF_REQ);

    state_t      state, state_nx, cur;
    logic [15:0] pow_cnt;
    logic [7:0]  gap_cnt;
    logic        nop, pre, aref, lmr, lmr_ok;
    logic        fail, aref_inc, aref_clr, mr_load;
    logic [2:0]  cause;

    assign nop  = cmd_i[3] || cmd_i == 4'b0111;
    assign pre  = cmd_i == 4'b0010;
    assign aref = cmd_i == 4'b0001;
    assign lmr  = cmd_i == 4'b0000;
    assign lmr_ok = ba_i == '0 && addr_i[ADDR_WIDTH-1:10] == '0 && addr_i[8:7] == 2'b00
                 && (!addr_i[2] || addr_i[2:0] == 3'b111) && addr_i[6:5] == 2'b01;

    // Once power-up time is met, the same cycle's command is judged as the first real command.
    assign cur = (state == M_PWR && pow_cnt == POW) ? M_WPRE : state;

    always_comb begin
        state_nx = cur;
        fail     = 1'b0;
        cause    = 3'd0;
        aref_inc = 1'b0;
        aref_clr = 1'b0;
        mr_load  = 1'b0;
        case (cur)
            M_PWR: if (!nop) {fail, cause} = 4'b1001;
            M_WPRE: begin
                if (pre && addr_i[10]) begin
                    state_nx = M_TRP;
                    aref_clr = 1'b1;
                end else if (!nop) {fail, cause} = 4'b1010;
            end
            M_TRP: begin
                if (!nop) begin
                    if (gap_cnt < RP) {fail, cause} = 4'b1011;
                    else if (aref) begin
                        state_nx = M_TRFC;
                        aref_inc = 1'b1;
                    end else {fail, cause} = 4'b1010;
                end
            end
            M_TRFC: begin
                if (!nop) begin
                    if (gap_cnt < RFC) {fail, cause} = 4'b1100;
                    else if (aref) aref_inc = 1'b1;
                    else if (lmr && aref_cnt_o >= AREF_MIN) begin
                        if (lmr_ok) begin
                            mr_load  = 1'b1;
                            state_nx = M_TMRD;
                        end else {fail, cause} = 4'b1101;
                    end else {fail, cause} = 4'b1010;
                end
            end
            M_TMRD: begin
                if (!nop) {fail, cause} = 4'b1110;
                else if (gap_cnt >= MRD_LAST) state_nx = M_READY;
            end
            M_READY: begin
                aref_inc = aref;
                aref_clr = pre;
                if (lmr && lmr_ok) mr_load = 1'b1;
                else if (lmr) {fail, cause} = 4'b1101;
            end
            default: ;
        endcase
        if (fail) state_nx = M_ERR;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= M_PWR;
            pow_cnt     <= '0;
            gap_cnt     <= '0;
            aref_cnt_o  <= '0;
            dev_ready_o <= 1'b0;
            mr_valid_o  <= 1'b0;
            mr_bl_o     <= '0;
            mr_bt_o     <= 1'b0;
            mr_cl_o     <= '0;
            mr_wbm_o    <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
        end else begin
            state       <= state_nx;
            dev_ready_o <= state_nx == M_READY;
            if (mon_en_i && pow_cnt < POW) pow_cnt <= pow_cnt + 16'd1;
            gap_cnt <= nop ? gap_cnt + {7'd0, gap_cnt != 8'hff} : 8'd0;
            if (aref_clr) aref_cnt_o <= '0;
            else if (aref_inc && aref_cnt_o != 4'hf) aref_cnt_o <= aref_cnt_o + 4'd1;
            if (mr_load) begin
                mr_valid_o <= 1'b1;
                mr_bl_o    <= addr_i[2:0];
                mr_bt_o    <= addr_i[3];
                mr_cl_o    <= addr_i[6:4];
                mr_wbm_o   <= addr_i[9];
            end
            if (fail) begin
                err_o      <= 1'b1;
                err_code_o <= cause;
            end
        end
    end
endmodule

// File: tb/tb_ddr_init_monitor.sv
// tb_ddr_init_monitor: randomized init sequences with injected faults, checked every cycle
// against a rule-level reference model of the power-up protocol.
module tb_ddr_init_monitor;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        mon_en_i = 1'b0;
    logic [3:0]  cmd_i = 4'b0111;
    logic [1:0]  ba_i = '0;
    logic [12:0] addr_i = '0;
    logic        dev_ready_o, mr_valid_o, mr_bt_o, mr_wbm_o, err_o;
    logic [2:0]  mr_bl_o, mr_cl_o, err_code_o;
    logic [3:0]  aref_cnt_o;

    ddr_init_monitor dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_en_i(mon_en_i), .cmd_i(cmd_i),
        .ba_i(ba_i), .addr_i(addr_i), .dev_ready_o(dev_ready_o), .mr_valid_o(mr_valid_o),
        .mr_bl_o(mr_bl_o), .mr_bt_o(mr_bt_o), .mr_cl_o(mr_cl_o), .mr_wbm_o(mr_wbm_o),
        .aref_cnt_o(aref_cnt_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 power-up/await PRE, 1 await first AREF, 2 refresh/await LMR,
    // 3 mode-register settle, 4 ready, 5 error.
    int m_pow, m_gap, m_phase, m_aref, m_code, m_mv, m_bl, m_bt, m_cl, m_wbm;

    task automatic model_reset();
        m_pow = 0; m_gap = 0; m_phase = 0; m_aref = 0; m_code = 0;
        m_mv = 0; m_bl = 0; m_bt = 0; m_cl = 0; m_wbm = 0;
    endtask

    function automatic int kind_of(input logic [3:0] c);
        if (c[3] || c == 4'b0111) return 0;
        if (c == 4'b0010) return 1;
        if (c == 4'b0001) return 2;
        if (c == 4'b0000) return 3;
        return 4;
    endfunction

    function automatic bit mode_ok(input int b, input int a);
        int bl = a % 8;
        int cl = (a / 16) % 8;
        return b == 0 && a / 1024 == 0 && (a / 128) % 4 == 0 && (bl <= 3 || bl == 7) && (cl == 2 || cl == 3);
    endfunction

    task automatic m_fail(input int c);
        m_phase = 5;
        m_code = c;
    endtask

    task automatic m_load(input int a);
        m_mv = 1; m_bl = a % 8; m_bt = (a / 8) % 2; m_cl = (a / 16) % 8; m_wbm = (a / 512) % 2;
    endtask

    task automatic m_lmr(input int b, input int a, input int next_phase);
        if (mode_ok(b, a)) begin
            m_load(a);
            m_phase = next_phase;
        end else m_fail(5);
    endtask

    task automatic model_step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input bit en);
        int k = kind_of(c);
        int ai = int'(a);
        int bi = int'(b);
        if (k != 0) begin
            case (m_phase)
                0: if (m_pow < 350) m_fail(1);
                   else if (k == 1 && a[10]) begin m_phase = 1; m_aref = 0; end
                   else m_fail(2);
                1: if (m_gap < 4) m_fail(3);
                   else if (k == 2) begin m_phase = 2; m_aref = 1; end
                   else m_fail(2);
                2: if (m_gap < 12) m_fail(4);
                   else if (k == 2) m_aref = (m_aref < 15) ? m_aref + 1 : 15;
                   else if (k == 3 && m_aref >= 2) m_lmr(bi, ai, 3);
                   else m_fail(2);
                3: m_fail(6);
                4: if (k == 1) m_aref = 0;
                   else if (k == 2) m_aref = (m_aref < 15) ? m_aref + 1 : 15;
                   else if (k == 3) m_lmr(bi, ai, 4);
                default: ;
            endcase
        end
        m_gap = (k == 0) ? ((m_gap < 255) ? m_gap + 1 : 255) : 0;
        if (en && m_pow < 350) m_pow++;
        if (m_phase == 3 && m_gap >= 6) m_phase = 4;
    endtask

    function automatic logic [17:0] exp_vec();
        return {1'(m_phase == 4), 1'(m_mv), 3'(m_bl), 1'(m_bt), 3'(m_cl), 1'(m_wbm),
                4'(m_aref), 1'(m_code != 0), 3'(m_code)};
    endfunction

    function automatic logic [17:0] got_vec();
        return {dev_ready_o, mr_valid_o, mr_bl_o, mr_bt_o, mr_cl_o, mr_wbm_o, aref_cnt_o, err_o, err_code_o};
    endfunction

    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input bit en);
        @(negedge sys_clk);
        cmd_i = c; ba_i = b; addr_i = a; mon_en_i = en;
        @(posedge sys_clk);
        model_step(c, b, a, en);
        #1 chk("outs", 32'(got_vec()), 32'(exp_vec()));
    endtask

    function automatic logic [3:0] rnd_nop();
        return ($urandom_range(0, 3) == 0) ? {1'b1, 3'($urandom)} : 4'b0111;
    endfunction

    function automatic logic [3:0] rnd_other();
        logic [3:0] t [4] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110};
        return t[$urandom_range(0, 3)];
    endfunction

    task automatic nop(input int n, input bit force_en);
        repeat (n) cyc(rnd_nop(), 2'($urandom), 13'($urandom), force_en ? 1'b1 : 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; mon_en_i = 1'b0; cmd_i = 4'b0111;
        #1 chk("reset", 32'(got_vec()), 32'd0);
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    function automatic logic [12:0] mode_word(input bit bad, output logic [1:0] b);
        int bl_t [5] = '{0, 1, 2, 3, 7};
        int bl = bl_t[$urandom_range(0, 4)];
        int cl = $urandom_range(2, 3);
        int v;
        logic [12:0] a;
        b = 2'b00;
        if (bad) begin
            case ($urandom_range(0, 4))
                0: b = 2'($urandom_range(1, 3));
                1: a = 13'(1 << (10 + $urandom_range(0, 2)));
                2: a = 13'($urandom_range(1, 3) << 7);
                3: bl = $urandom_range(4, 6);
                default: begin v = $urandom_range(0, 5); cl = (v < 2) ? v : v + 2; end
            endcase
        end
        if (!bad || a === 13'bx || a == 0) a = '0;
        return a | 13'(bl) | 13'($urandom_range(0, 1) << 3) | 13'(cl << 4) | 13'($urandom_range(0, 1) << 9);
    endfunction

    // Fault f: 0 none, 1 early cmd, 2 order, 3 tRP, 4 tRFC, 5 bad LMR, 6 tMRD, 7 reset mid-refresh.
    task automatic attempt(input int f);
        int sub = $urandom_range(0, 2);
        int n_aref;
        logic [12:0] a;
        logic [1:0] b;
        if (f == 1) begin
            nop($urandom_range(1, 349), 1'b1);
            cyc(($urandom_range(0, 1) == 0) ? 4'b0010 : rnd_other(), 2'($urandom), 13'h400, 1'b1);
        end else begin
            while (m_pow < 350) cyc(rnd_nop(), 2'($urandom), 13'($urandom), $urandom_range(0, 9) < 7);
        end
        nop($urandom_range(0, 3), 1'b0);
        a = 13'($urandom);
        a[10] = !(f == 2 && sub == 0);
        cyc(4'b0010, 2'($urandom), a, 1'b1);
        nop((f == 3) ? $urandom_range(0, 3) : $urandom_range(4, 6), 1'b0);
        if (f == 2 && sub == 1) cyc(rnd_other(), 2'($urandom), 13'($urandom), 1'b1);
        n_aref = (f == 2 && sub == 2) ? 1 : 2 + $urandom_range(0, 3);
        for (int i = 0; i < n_aref; i++) begin
            cyc(4'b0001, 2'($urandom), 13'($urandom), 1'b1);
            nop((f == 4 && i == n_aref - 1) ? $urandom_range(0, 11) : $urandom_range(12, 14), 1'b0);
            if (f == 7 && i == 0) begin
                do_reset();
                return;
            end
        end
        a = mode_word(f == 5, b);
        cyc(4'b0000, b, a, 1'b1);
        if (f == 6) begin
            nop($urandom_range(0, 5), 1'b0);
            cyc(rnd_other(), 2'($urandom), 13'($urandom), 1'b1);
        end else nop($urandom_range(6, 8), 1'b0);
    endtask

    task automatic run(input int f);
        logic [1:0] b;
        logic [12:0] a;
        int r;
        attempt(f);
        if (f == 7) attempt(0);
        chk("seq_ready", 32'(dev_ready_o), 32'(m_phase == 4));
        chk("seq_err", 32'(err_o), 32'(m_code != 0));
        chk("seq_code", 32'(err_code_o), 32'(m_code));
        chk("seq_aref", 32'(aref_cnt_o), 32'(m_aref));
        chk("seq_mr", 32'({mr_valid_o, mr_bl_o, mr_cl_o}), 32'({1'(m_mv), 3'(m_bl), 3'(m_cl)}));
        repeat (20) begin
            r = $urandom_range(0, 9);
            if (r <= 5) nop(1, 1'b0);
            else if (r == 6) cyc(4'b0010, 2'($urandom), 13'($urandom), 1'b1);
            else if (r == 7) cyc(4'b0001, 2'($urandom), 13'($urandom), 1'b1);
            else if (r == 8) begin
                a = mode_word($urandom_range(0, 3) == 0, b);
                cyc(4'b0000, b, a, 1'b1);
            end else cyc(rnd_other(), 2'($urandom), 13'($urandom), 1'b1);
        end
        chk("tail_err", 32'(err_code_o), 32'(m_code));
        do_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        for (int rep = 0; rep < 3; rep++)
            for (int f = 0; f < 8; f++) run(f);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
